// File: rtl/mpmc11_pkg.sv
// mpmc11_pkg: shared state encoding, UI command codes and registered output bundle for the MPMC11 sequencer.
package mpmc11_pkg;
  typedef enum logic [3:0] {
    IDLE, PRESET1, PRESET2, WRITE_DATA0, WRITE_DATA1, WRITE_CMD,
    READ_CMD, READ_DATA0, READ_DATA1, DONE
  } mpmc11_state_t;
  localparam logic [2:0] CMD_WRITE = 3'b000;
  localparam logic [2:0] CMD_READ  = 3'b001;
  typedef struct packed {
    logic       ack;
    logic       err;
    logic       app_en;
    logic [2:0] app_cmd;
    logic       app_wdf_wren;
    logic       app_wdf_end;
    logic       rd_beat;
  } ui_out_t;
  function automatic logic is_wait(input mpmc11_state_t s);
    return s inside {WRITE_DATA0, WRITE_DATA1, WRITE_CMD, READ_CMD, READ_DATA0, READ_DATA1};
  endfunction
endpackage

// File: rtl/mpmc11_timeout_ctr.sv
// mpmc11_timeout_ctr: saturating wait-cycle counter flagging when a limit is reached (limit 0 disables).
module mpmc11_timeout_ctr #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] limit,
  output logic         expired
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clr ? '0 : (en && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk)
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  // cnt_q counts cycles already spent, so the limit-th waiting cycle is the last one
  assign expired = en && limit != '0 && cnt_q >= limit - 1'b1;
endmodule

// File: rtl/mpmc11_cmd_sequencer.sv
// mpmc11_cmd_sequencer: runs one arbiter request at a time through the two-beat DDR UI handshake.
module mpmc11_cmd_sequencer
  import mpmc11_pkg::*;
#(
  parameter int AWID   = 32,
  parameter int TO_CYC = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req,
  input  logic            we,
  input  logic [AWID-1:0] adr,
  output logic            ack,
  output logic            err,
  output mpmc11_state_t   state,
  output logic            app_en,
  output logic [2:0]      app_cmd,
  output logic [AWID-1:0] app_addr,
  input  logic            app_rdy,
  output logic            app_wdf_wren,
  output logic            app_wdf_end,
  input  logic            app_wdf_rdy,
  input  logic            app_rd_data_valid,
  output logic            rd_beat
);
  localparam logic [AWID-1:0] ALIGN = ~AWID'(4'hF);
  mpmc11_state_t   state_q, state_d;
  ui_out_t         out_q, out_d;
  logic            we_q, we_d;
  logic [AWID-1:0] addr_q, addr_d;
  logic            hs, expired, to;
  always_comb begin
    hs = (state_q inside {WRITE_DATA0, WRITE_DATA1} && app_wdf_rdy) ||
         (state_q inside {WRITE_CMD, READ_CMD} && app_rdy) ||
         (state_q inside {READ_DATA0, READ_DATA1} && app_rd_data_valid);
    to = is_wait(state_q) && !hs && expired;
    we_d = (state_q == IDLE && req) ? we : we_q;
    addr_d = (state_q == IDLE && req) ? adr & ALIGN : addr_q;
    case (state_q)
      IDLE:        state_d = req ? PRESET1 : IDLE;
      PRESET1:     state_d = PRESET2;
      PRESET2:     state_d = we_q ? WRITE_DATA0 : READ_CMD;
      WRITE_DATA0: state_d = hs ? WRITE_DATA1 : state_q;
      WRITE_DATA1: state_d = hs ? WRITE_CMD : state_q;
      WRITE_CMD:   state_d = hs ? DONE : state_q;
      READ_CMD:    state_d = hs ? READ_DATA0 : state_q;
      READ_DATA0:  state_d = hs ? READ_DATA1 : state_q;
      READ_DATA1:  state_d = hs ? DONE : state_q;
      default:     state_d = IDLE;
    endcase
    if (to) state_d = DONE;
    // outputs decode the next state so they line up with state_q after the edge
    out_d.ack = state_d == DONE;
    out_d.err = to;
    out_d.app_en = state_d inside {WRITE_CMD, READ_CMD};
    out_d.app_cmd = state_d == READ_CMD ? CMD_READ : CMD_WRITE;
    out_d.app_wdf_wren = state_d inside {WRITE_DATA0, WRITE_DATA1};
    out_d.app_wdf_end = state_d == WRITE_DATA1;
    out_d.rd_beat = state_d == READ_DATA1;
  end
  always_ff @(posedge clk)
    if (rst) begin
      state_q <= IDLE;
      out_q <= '0;
      we_q <= 1'b0;
      addr_q <= '0;
    end else begin
      state_q <= state_d;
      out_q <= out_d;
      we_q <= we_d;
      addr_q <= addr_d;
    end
  mpmc11_timeout_ctr #(.W(8)) u_to (
    .clk(clk),
    .rst(rst),
    .clr(state_d != state_q),
    .en(is_wait(state_q)),
    .limit(8'(TO_CYC)),
    .expired(expired)
  );
  assign state = state_q;
  assign app_addr = addr_q;
  assign ack = out_q.ack;
  assign err = out_q.err;
  assign app_en = out_q.app_en;
  assign app_cmd = out_q.app_cmd;
  assign app_wdf_wren = out_q.app_wdf_wren;
  assign app_wdf_end = out_q.app_wdf_end;
  assign rd_beat = out_q.rd_beat;
endmodule

// File: tb/tb_mpmc11_cmd_sequencer.sv
// tb_mpmc11_cmd_sequencer: directed stimulus with a completion scoreboard for the MPMC11 command sequencer.
module tb_mpmc11_cmd_sequencer;
  import mpmc11_pkg::*;
  typedef struct {
    logic        err;
    logic [31:0] addr;
    int          beats;
  } exp_t;
  logic clk = 0, rst = 1, req = 0, we = 0, app_rdy = 1, app_wdf_rdy = 1, app_rd_data_valid = 0;
  logic [31:0] adr = '0, app_addr;
  logic ack, err, app_en, app_wdf_wren, app_wdf_end, rd_beat;
  logic [2:0] app_cmd;
  mpmc11_state_t state;
  exp_t sb[$];
  exp_t e;
  int compared = 0, mismatched = 0, beats = 0;
  int acks, t1, t2;
  mpmc11_state_t wseq[6] = '{PRESET1, PRESET2, WRITE_DATA0, WRITE_DATA1, WRITE_CMD, DONE};

  mpmc11_cmd_sequencer #(.AWID(32), .TO_CYC(16)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .adr(adr), .ack(ack), .err(err),
    .state(state), .app_en(app_en), .app_cmd(app_cmd), .app_addr(app_addr),
    .app_rdy(app_rdy), .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end),
    .app_wdf_rdy(app_wdf_rdy), .app_rd_data_valid(app_rd_data_valid), .rd_beat(rd_beat)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // transfers are counted on the edge using pre-edge values; each ack retires one scoreboard entry
  always @(posedge clk) begin
    if (rst) begin
      sb.delete();
      beats = 0;
    end else begin
      if ((app_wdf_wren && app_wdf_rdy) ||
          ((state == READ_DATA0 || state == READ_DATA1) && app_rd_data_valid)) beats++;
      if (ack) begin
        if (sb.size() == 0) chk("ack_without_request", 32'd1, 32'd0);
        else begin
          e = sb.pop_front();
          chk("sb_err", 32'(err), 32'(e.err));
          chk("sb_addr", app_addr, e.addr);
          chk("sb_beats", beats, e.beats);
        end
        beats = 0;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tick();
    tick();
    chk("rst_state", 32'(state), 32'(IDLE));
    chk("rst_outs", {ack, err, app_en, app_cmd, app_wdf_wren, app_wdf_end, rd_beat}, 32'd0);
    chk("rst_addr", app_addr, 32'd0);
    rst = 0;
    // 1: write, everything ready
    req = 1; we = 1; adr = 32'h1234_5678;
    sb.push_back('{1'b0, 32'h1234_5670, 2});
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("w1_state", 32'(state), 32'(wseq[i]));
      chk("w1_ack", 32'(ack), 32'(i == 5));
      if (i == 0) chk("w1_addr", app_addr, 32'h1234_5670);
      if (i == 1) adr = 32'hFFFF_FFFF;
      if (i == 4) chk("w1_addr_held", app_addr, 32'h1234_5670);
    end
    chk("w1_err", 32'(err), 32'd0);
    req = 0;
    tick();
    chk("w1_idle", 32'(state), 32'(IDLE));
    // 2: write with app_wdf_rdy stalled during the second beat
    req = 1; we = 1; adr = 32'h0000_00A5;
    sb.push_back('{1'b0, 32'h0000_00A0, 2});
    tick(); tick(); tick();
    chk("w2_wd0", 32'(state), 32'(WRITE_DATA0));
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("w2_wd1", 32'(state), 32'(WRITE_DATA1));
      chk("w2_wren_end", {app_wdf_wren, app_wdf_end}, 32'd3);
      app_wdf_rdy = (i == 2);
    end
    tick();
    chk("w2_wc", {28'(state), app_en, app_cmd}, {28'(WRITE_CMD), 1'b1, CMD_WRITE});
    tick();
    chk("w2_done_ack", 32'(ack), 32'd1);
    req = 0;
    tick();
    // 3: read with command stall and sparse read beats
    req = 1; we = 0; adr = 32'h8000_001F; app_rdy = 0;
    sb.push_back('{1'b0, 32'h8000_0010, 2});
    tick(); tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("r3_rc", {28'(state), app_en, app_cmd}, {28'(READ_CMD), 1'b1, CMD_READ});
      app_rdy = (i == 2);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("r3_rd0", {28'(state), 3'b0, rd_beat}, {28'(READ_DATA0), 4'b0});
      app_rd_data_valid = (i == 3);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("r3_rd1", {28'(state), 3'b0, rd_beat}, {28'(READ_DATA1), 4'b1});
      app_rd_data_valid = (i == 3);
    end
    tick();
    app_rd_data_valid = 0;
    chk("r3_done", {ack, err}, 32'd2);
    req = 0;
    tick();
    // 4: read that never gets data times out after 16 cycles
    req = 1; we = 0; adr = 32'h0000_0040;
    sb.push_back('{1'b1, 32'h0000_0040, 0});
    tick(); tick(); tick();
    for (int i = 0; i < 16; i++) begin
      tick();
      chk("r4_wait", 32'(state), 32'(READ_DATA0));
    end
    tick();
    chk("r4_timeout", {28'(state), 2'b0, ack, err}, {28'(DONE), 4'b0011});
    req = 0;
    tick();
    chk("r4_idle", {28'(state), 3'b0, ack}, {28'(IDLE), 4'b0});
    // 5: reset during WRITE_CMD, then a clean write
    req = 1; we = 1; adr = 32'h2000_0000;
    sb.push_back('{1'b0, 32'h2000_0000, 2});
    repeat (5) tick();
    chk("w5_wc", 32'(state), 32'(WRITE_CMD));
    rst = 1; req = 0;
    tick();
    chk("w5_rst", {28'(state), 2'b0, app_en, ack}, {28'(IDLE), 4'b0});
    rst = 0;
    req = 1; adr = 32'h3000_0004;
    sb.push_back('{1'b0, 32'h3000_0000, 2});
    acks = 0;
    for (int i = 0; i < 20 && acks == 0; i++) begin
      tick();
      if (ack) acks++;
    end
    chk("w5_recover_ack", acks, 32'd1);
    req = 0;
    tick();
    // 6: req held through DONE gives back-to-back writes; stray read valid in IDLE
    req = 1; we = 1; adr = 32'h0000_0055;
    sb.push_back('{1'b0, 32'h0000_0050, 2});
    sb.push_back('{1'b0, 32'h0000_0050, 2});
    acks = 0; t1 = 0; t2 = 0;
    for (int i = 0; i < 30 && acks < 2; i++) begin
      tick();
      app_rd_data_valid = (state == IDLE);
      if (ack) begin
        acks++;
        if (acks == 1) t1 = i; else t2 = i;
      end
    end
    req = 0;
    app_rd_data_valid = 0;
    chk("b6_acks", acks, 32'd2);
    chk("b6_spacing", t2 - t1, 32'd7);
    tick();
    chk("b6_idle", 32'(state), 32'(IDLE));
    tick();
    chk("sb_drained", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
